// File: rtl/vid_stream_out.sv
// Video output stage. A flagged pixel stream is buffered in a small FIFO and
// locked onto a free-running raster that drives registered pixel/DE/sync outputs.
module vid_stream_out #(
  parameter int H_ACTIVE   = 1280,
  parameter int H_FP       = 110,
  parameter int H_SYNC     = 40,
  parameter int H_BP       = 220,
  parameter int V_ACTIVE   = 720,
  parameter int V_FP       = 5,
  parameter int V_SYNC     = 5,
  parameter int V_BP       = 20,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] i_color,
  input  logic        i_valid,
  input  logic        i_start,
  input  logic        i_last,
  output logic        o_ready,
  output logic [23:0] vid_data,
  output logic        vid_de,
  output logic        vid_hsync,
  output logic        vid_vsync,
  output logic        o_locked,
  output logic        o_underflow,
  output logic        o_misalign,
  output logic [1:0]  dbg_state
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_LAST_ACT = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] HS_START   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] FIFO_FULL  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_SEARCH     = 2'd0,
    S_WAIT_FRAME = 2'd1,
    S_LOCKED     = 2'd2,
    S_FLUSH      = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          active, at_origin, line_end;

  logic [25:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty;
  logic [25:0]   head;
  logic          head_start, head_last;

  logic ready_en;
  logic accept, wr_en, pop, flush, fault_uf, fault_mis, mismatch;

  // Raster runs continuously from reset, independent of lock state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign at_origin = (h_cnt == '0) && (v_cnt == '0);
  assign line_end  = (h_cnt == H_LAST_ACT);

  // Handshake: a beat transfers on a rising edge where i_valid && o_ready.
  // o_ready depends only on registered state (no same-cycle bypass), so the
  // source must hold i_color/i_start/i_last stable while i_valid && !o_ready.
  assign full    = (count == FIFO_FULL);
  assign empty   = (count == '0);
  assign o_ready = ready_en && !full && (state != S_FLUSH);
  assign accept  = i_valid && o_ready;

  assign head       = mem[rd_ptr];
  assign head_start = head[25];
  assign head_last  = head[24];
  assign mismatch   = (head_start != at_origin) || (head_last != line_end);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ready_en <= 1'b0;
    else       ready_en <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {i_start, i_last, i_color};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_SEARCH;
    else       state <= state_nxt;
  end

  // The head popped at the origin in WAIT_FRAME is always the start beat,
  // since SEARCH only ever writes from a start beat onwards.
  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    pop       = 1'b0;
    flush     = 1'b0;
    fault_uf  = 1'b0;
    fault_mis = 1'b0;
    case (state)
      S_SEARCH: begin
        if (accept && i_start) begin
          wr_en     = 1'b1;
          state_nxt = S_WAIT_FRAME;
        end
      end
      S_WAIT_FRAME: begin
        wr_en = accept;
        if (at_origin && !empty) begin
          pop = 1'b1;
          if (mismatch) begin
            fault_mis = 1'b1;
            state_nxt = S_FLUSH;
          end else begin
            state_nxt = S_LOCKED;
          end
        end
      end
      S_LOCKED: begin
        wr_en = accept;
        if (active) begin
          if (empty) begin
            fault_uf  = 1'b1;
            state_nxt = S_FLUSH;
          end else begin
            pop = 1'b1;
            if (mismatch) begin
              fault_mis = 1'b1;
              state_nxt = S_FLUSH;
            end
          end
        end
      end
      S_FLUSH: begin
        flush     = 1'b1;
        state_nxt = S_SEARCH;
      end
      default: state_nxt = S_SEARCH;
    endcase
  end

  // Lock stays up through the faulting pixel and drops one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vid_data    <= '0;
      vid_de      <= 1'b0;
      vid_hsync   <= 1'b0;
      vid_vsync   <= 1'b0;
      o_locked    <= 1'b0;
      o_underflow <= 1'b0;
      o_misalign  <= 1'b0;
    end else begin
      vid_data    <= (pop && !fault_mis) ? head[23:0] : '0;
      vid_de      <= active;
      vid_hsync   <= (h_cnt >= HS_START) && (h_cnt < HS_END);
      vid_vsync   <= (v_cnt >= VS_START) && (v_cnt < VS_END);
      o_locked    <= (state == S_LOCKED) || (state_nxt == S_LOCKED);
      o_underflow <= fault_uf;
      o_misalign  <= fault_mis;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_vid_stream_out.sv
// Directed bench for vid_stream_out on a 14x7 raster (8x4 active) with an
// 8-entry FIFO: raster timing, lock, underflow, misalign and mid-frame reset.
module tb_vid_stream_out;

  localparam int HT = 14;
  localparam int VT = 7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] i_color;
  logic        i_valid, i_start, i_last;
  logic        o_ready;
  logic [23:0] vid_data;
  logic        vid_de, vid_hsync, vid_vsync;
  logic        o_locked, o_underflow, o_misalign;
  logic [1:0]  dbg_state;

  vid_stream_out #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .reset(reset),
    .i_color(i_color), .i_valid(i_valid), .i_start(i_start), .i_last(i_last),
    .o_ready(o_ready),
    .vid_data(vid_data), .vid_de(vid_de), .vid_hsync(vid_hsync), .vid_vsync(vid_vsync),
    .o_locked(o_locked), .o_underflow(o_underflow), .o_misalign(o_misalign),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [25:0] src_q[$];
  logic [23:0] exp_q[$];
  bit          hold = 1'b0;
  int          cyc = 0;

  logic        s_de, s_hs, s_vs, s_lock, s_uf, s_mis, s_rdy;
  logic [23:0] s_data;
  int          s_p, s_h, s_v;

  // driver: one clock of source drive, mid-cycle output sample, handshake
  task automatic tick();
    logic fire;
    if (!hold && src_q.size() > 0) begin
      i_valid = 1'b1;
      {i_start, i_last, i_color} = src_q[0];
    end else begin
      i_valid = 1'b0; i_start = 1'b0; i_last = 1'b0; i_color = '0;
    end
    @(negedge clk);
    s_de = vid_de; s_hs = vid_hsync; s_vs = vid_vsync; s_data = vid_data;
    s_lock = o_locked; s_uf = o_underflow; s_mis = o_misalign; s_rdy = o_ready;
    fire = i_valid && o_ready;
    s_p = cyc - 1;
    s_h = (s_p >= 0) ? s_p % HT : -1;
    s_v = (s_p >= 0) ? (s_p / HT) % VT : -1;
    @(posedge clk); #1;
    if (fire) void'(src_q.pop_front());
    cyc++;
  endtask

  task automatic push_beats(input int base, input int n, input int len);
    for (int i = 0; i < n; i++)
      src_q.push_back({(i == 0), ((i % len) == (len - 1)), 24'(base + i)});
  endtask

  task automatic push_exp(input int base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(24'(base + i));
  endtask

  task automatic test_reset();
    i_valid = 1'b0; i_start = 1'b0; i_last = 1'b0; i_color = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (vid_de !== 1'b0) begin n_err++; $display("FAIL reset_de: got %0h want 0", vid_de); end
    n_cmp++; if (vid_data !== 24'h0) begin n_err++; $display("FAIL reset_data: got %0h want 0", vid_data); end
    n_cmp++; if (vid_hsync !== 1'b0) begin n_err++; $display("FAIL reset_hsync: got %0h want 0", vid_hsync); end
    n_cmp++; if (vid_vsync !== 1'b0) begin n_err++; $display("FAIL reset_vsync: got %0h want 0", vid_vsync); end
    n_cmp++; if (o_locked !== 1'b0) begin n_err++; $display("FAIL reset_locked: got %0h want 0", o_locked); end
    n_cmp++; if (o_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %0h want 0", o_ready); end
    n_cmp++; if (o_underflow !== 1'b0) begin n_err++; $display("FAIL reset_uf: got %0h want 0", o_underflow); end
    n_cmp++; if (o_misalign !== 1'b0) begin n_err++; $display("FAIL reset_mis: got %0h want 0", o_misalign); end
    reset = 1'b0;
    cyc = 0;
    tick();
    n_cmp++; if (s_rdy !== 1'b0) begin n_err++; $display("FAIL pre_edge_ready: got %0h want 0", s_rdy); end
    n_cmp++; if (s_de !== 1'b0) begin n_err++; $display("FAIL pre_edge_de: got %0h want 0", s_de); end
    tick();
    n_cmp++; if (s_de !== 1'b1) begin n_err++; $display("FAIL first_de: got %0h want 1", s_de); end
    n_cmp++; if (s_data !== 24'h0) begin n_err++; $display("FAIL first_data: got %0h want 0", s_data); end
    n_cmp++; if (s_rdy !== 1'b1) begin n_err++; $display("FAIL first_ready: got %0h want 1", s_rdy); end
  endtask

  task automatic test_raster();
    int n_de = 0, n_hs = 0, n_vs = 0;
    logic e_de, e_hs, e_vs;
    for (int t = 0; t < 2 * HT * VT; t++) begin
      tick();
      e_de = (s_h < 8) && (s_v < 4);
      e_hs = (s_h >= 10) && (s_h < 12);
      e_vs = (s_v == 5);
      n_de += int'(s_de); n_hs += int'(s_hs); n_vs += int'(s_vs);
      n_cmp++; if (s_de !== e_de) begin n_err++; $display("FAIL raster_de p=%0d: got %0h want %0h", s_p, s_de, e_de); end
      n_cmp++; if (s_hs !== e_hs) begin n_err++; $display("FAIL raster_hsync p=%0d: got %0h want %0h", s_p, s_hs, e_hs); end
      n_cmp++; if (s_vs !== e_vs) begin n_err++; $display("FAIL raster_vsync p=%0d: got %0h want %0h", s_p, s_vs, e_vs); end
      n_cmp++; if (s_data !== 24'h0) begin n_err++; $display("FAIL raster_data p=%0d: got %0h want 0", s_p, s_data); end
      n_cmp++; if (s_lock !== 1'b0) begin n_err++; $display("FAIL raster_locked p=%0d: got %0h want 0", s_p, s_lock); end
    end
    n_cmp++; if (n_de != 64) begin n_err++; $display("FAIL raster_de_count: got %0d want 64", n_de); end
    n_cmp++; if (n_hs != 28) begin n_err++; $display("FAIL raster_hs_count: got %0d want 28", n_hs); end
    n_cmp++; if (n_vs != 28) begin n_err++; $display("FAIL raster_vs_count: got %0d want 28", n_vs); end
  endtask

  // Source always valid: junk beats dropped, then two frames back to back.
  task automatic test_lock();
    bit found = 1'b0;
    bit full_blank = 1'b0;
    int t = 0;
    for (int i = 0; i < 3; i++) src_q.push_back({2'b00, 24'hAA0000 + 24'(i)});
    push_beats(1, 32, 8);
    push_beats(33, 32, 8);
    push_exp(1, 32);
    while (exp_q.size() > 0 && t < 400) begin
      tick(); t++;
      if (!found && s_lock) begin
        found = 1'b1;
        n_cmp++; if (s_h != 0 || s_v != 0) begin n_err++; $display("FAIL lock_origin: got h=%0d v=%0d want 0,0", s_h, s_v); end
        n_cmp++; if (s_de !== 1'b1) begin n_err++; $display("FAIL lock_de: got %0h want 1", s_de); end
      end
      if (!found) begin
        n_cmp++; if (s_data !== 24'h0) begin n_err++; $display("FAIL unlocked_data: got %0h want 0", s_data); end
      end else begin
        n_cmp++; if (s_lock !== 1'b1) begin n_err++; $display("FAIL lock_hold p=%0d: got %0h want 1", s_p, s_lock); end
        n_cmp++; if (s_uf !== 1'b0 || s_mis !== 1'b0) begin n_err++; $display("FAIL lock_faults: got uf=%0h mis=%0h want 0", s_uf, s_mis); end
        if (s_de) begin
          n_cmp++; if (s_data !== exp_q[0]) begin n_err++; $display("FAIL lock_data: got %0h want %0h", s_data, exp_q[0]); end
          void'(exp_q.pop_front());
        end
        if (!s_de && !s_rdy) full_blank = 1'b1;
      end
    end
    n_cmp++; if (!found || exp_q.size() != 0) begin n_err++; $display("FAIL lock_timeout: got found=%0d left=%0d want 1,0", found, exp_q.size()); end
    n_cmp++; if (!full_blank) begin n_err++; $display("FAIL ready_full_blank: got 0 want 1"); end
  endtask

  task automatic test_underflow();
    bit uf_seen = 1'b0, stalled = 1'b0, found = 1'b0;
    int hold_left = 0;
    int t = 0;
    push_beats(101, 32, 8);
    push_exp(33, 32);
    while (!uf_seen && t < 300) begin
      if (!stalled && s_lock && s_v == 1 && s_h == 3) begin
        stalled = 1'b1; hold = 1'b1; hold_left = 20;
      end
      tick(); t++;
      if (hold_left > 0) begin hold_left--; if (hold_left == 0) hold = 1'b0; end
      if (s_uf) begin
        uf_seen = 1'b1;
        n_cmp++; if (s_de !== 1'b1) begin n_err++; $display("FAIL uf_de: got %0h want 1", s_de); end
        n_cmp++; if (s_data !== 24'h0) begin n_err++; $display("FAIL uf_data: got %0h want 0", s_data); end
        n_cmp++; if (s_lock !== 1'b1) begin n_err++; $display("FAIL uf_lock_same: got %0h want 1", s_lock); end
        n_cmp++; if (s_mis !== 1'b0) begin n_err++; $display("FAIL uf_no_mis: got %0h want 0", s_mis); end
      end else if (s_de && exp_q.size() > 0) begin
        n_cmp++; if (s_data !== exp_q[0]) begin n_err++; $display("FAIL pre_uf_data: got %0h want %0h", s_data, exp_q[0]); end
        void'(exp_q.pop_front());
      end
    end
    n_cmp++; if (!uf_seen) begin n_err++; $display("FAIL uf_timeout: got 0 want 1"); end
    tick();
    if (hold_left > 0) begin hold_left--; if (hold_left == 0) hold = 1'b0; end
    n_cmp++; if (s_lock !== 1'b0) begin n_err++; $display("FAIL uf_lock_fall: got %0h want 0", s_lock); end
    n_cmp++; if (s_uf !== 1'b0) begin n_err++; $display("FAIL uf_single_pulse: got %0h want 0", s_uf); end
    exp_q.delete();
    push_exp(101, 32);
    t = 0;
    while (exp_q.size() > 0 && t < 400) begin
      tick(); t++;
      if (hold_left > 0) begin hold_left--; if (hold_left == 0) hold = 1'b0; end
      if (!found && s_lock) begin
        found = 1'b1;
        n_cmp++; if (s_h != 0 || s_v != 0) begin n_err++; $display("FAIL relock_origin: got h=%0d v=%0d want 0,0", s_h, s_v); end
      end
      if (!found) begin
        n_cmp++; if (s_data !== 24'h0 || s_uf !== 1'b0) begin n_err++; $display("FAIL flush_quiet: got data=%0h uf=%0h want 0,0", s_data, s_uf); end
      end else if (s_de) begin
        n_cmp++; if (s_data !== exp_q[0]) begin n_err++; $display("FAIL relock_data: got %0h want %0h", s_data, exp_q[0]); end
        void'(exp_q.pop_front());
      end
    end
    hold = 1'b0;
    n_cmp++; if (!found || exp_q.size() != 0) begin n_err++; $display("FAIL relock_timeout: got found=%0d left=%0d want 1,0", found, exp_q.size()); end
  endtask

  // Seven-pixel line with last on the seventh beat: fault at h=6.
  task automatic test_misalign();
    bit mis_seen = 1'b0;
    int t = 0;
    push_beats(201, 7, 7);
    push_exp(201, 6);
    while (!mis_seen && t < 300) begin
      tick(); t++;
      if (s_mis) begin
        mis_seen = 1'b1;
        n_cmp++; if (s_h != 6 || s_v != 0) begin n_err++; $display("FAIL mis_pos: got h=%0d v=%0d want 6,0", s_h, s_v); end
        n_cmp++; if (s_data !== 24'h0) begin n_err++; $display("FAIL mis_data: got %0h want 0", s_data); end
        n_cmp++; if (s_de !== 1'b1 || s_lock !== 1'b1) begin n_err++; $display("FAIL mis_de_lock: got de=%0h lock=%0h want 1,1", s_de, s_lock); end
        n_cmp++; if (s_uf !== 1'b0) begin n_err++; $display("FAIL mis_no_uf: got %0h want 0", s_uf); end
      end else if (s_de) begin
        n_cmp++; if (exp_q.size() == 0 || s_data !== exp_q[0]) begin n_err++; $display("FAIL pre_mis_data: got %0h left=%0d", s_data, exp_q.size()); end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
    n_cmp++; if (!mis_seen || exp_q.size() != 0) begin n_err++; $display("FAIL mis_timeout: got seen=%0d left=%0d want 1,0", mis_seen, exp_q.size()); end
    tick();
    n_cmp++; if (s_lock !== 1'b0 || s_mis !== 1'b0) begin n_err++; $display("FAIL mis_after: got lock=%0h mis=%0h want 0,0", s_lock, s_mis); end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    int t = 0;
    push_beats(301, 32, 8);
    while (!(s_lock && s_v == 1 && s_h == 4) && t < 300) begin
      tick(); t++;
    end
    n_cmp++; if (s_lock !== 1'b1 || s_data !== 24'd313) begin n_err++; $display("FAIL pre_reset_pixel: got lock=%0h data=%0h want 1,139", s_lock, s_data); end
    reset = 1'b1;
    i_valid = 1'b0;
    src_q.delete(); exp_q.delete();
    #1;
    n_cmp++; if (vid_de !== 1'b0 || vid_data !== 24'h0) begin n_err++; $display("FAIL async_clear_vid: got de=%0h data=%0h want 0,0", vid_de, vid_data); end
    n_cmp++; if (o_locked !== 1'b0 || o_ready !== 1'b0) begin n_err++; $display("FAIL async_clear_ctl: got lock=%0h rdy=%0h want 0,0", o_locked, o_ready); end
    n_cmp++; if (vid_hsync !== 1'b0 || vid_vsync !== 1'b0 || o_underflow !== 1'b0 || o_misalign !== 1'b0) begin
      n_err++; $display("FAIL async_clear_misc: got hs=%0h vs=%0h uf=%0h mis=%0h want 0", vid_hsync, vid_vsync, o_underflow, o_misalign);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
    push_beats(401, 32, 8);
    push_exp(401, 32);
    tick();
    tick();
    n_cmp++; if (s_de !== 1'b1 || s_data !== 24'h0 || s_lock !== 1'b0) begin
      n_err++; $display("FAIL post_reset_origin: got de=%0h data=%0h lock=%0h want 1,0,0", s_de, s_data, s_lock);
    end
    t = 0;
    while (exp_q.size() > 0 && t < 300) begin
      tick(); t++;
      if (!found && s_lock) begin
        found = 1'b1;
        n_cmp++; if (s_p != 98) begin n_err++; $display("FAIL post_reset_lock_pos: got %0d want 98", s_p); end
      end
      if (found && s_de) begin
        n_cmp++; if (s_data !== exp_q[0]) begin n_err++; $display("FAIL post_reset_data: got %0h want %0h", s_data, exp_q[0]); end
        void'(exp_q.pop_front());
      end
    end
    n_cmp++; if (!found || exp_q.size() != 0) begin n_err++; $display("FAIL post_reset_timeout: got found=%0d left=%0d want 1,0", found, exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_raster();
    test_lock();
    test_underflow();
    test_misalign();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vid_stream_out.md
# vid_stream_out

Video output stage downstream of the test pattern generator. It accepts the generator's 24-bit pixel stream (valid/ready handshake with start-of-frame and end-of-line flags) into a small FIFO. It produces a free-running raster with registered pixel, data-enable, hsync and vsync outputs at the configured timing (720p by default). It locks the incoming stream to the raster's first active pixel, and on any loss of alignment it drops lock and resynchronises.

## Interface
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, horizontal front porch (clocks)
- H_SYNC, 40, hsync width (clocks)
- H_BP, 220, horizontal back porch (clocks)
- V_ACTIVE, 720, active lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BP, 20, vertical back porch (lines)
- FIFO_DEPTH, 16, input FIFO entries (power of two, >=4)
- clk  in  1  pixel clock, all logic rising-edge
- reset  in  1  asynchronous, active-high; clears all state
- i_color  in  24  pixel data {R,G,B}
- i_valid  in  1  i_color/i_start/i_last valid
- i_start  in  1  first pixel of frame
- i_last  in  1  last pixel of line
- o_ready  out  1  beat accepted when i_valid && o_ready
- vid_data  out  24  displayed pixel, 0 outside active or when not locked
- vid_de  out  1  active-region enable
- vid_hsync  out  1  horizontal sync, active-high
- vid_vsync  out  1  vertical sync, active-high
- o_locked  out  1  stream locked to raster
- o_underflow  out  1  one-cycle pulse: FIFO empty at an active pixel while locked
- o_misalign  out  1  one-cycle pulse: start/last flag mismatch while locked

## Operation
- Raster: h_cnt 0..H_TOTAL-1 (H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP), v_cnt 0..V_TOTAL-1 increments when h_cnt wraps; free-running from reset regardless of lock. Active: h_cnt<H_ACTIVE && v_cnt<V_ACTIVE. hsync: H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC. vsync: V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, whole lines.
- FIFO stores {start,last,color}; write on i_valid && o_ready; o_ready = !full && !flush (registered occupancy, no same-cycle bypass).
- State SEARCH: o_locked=0; beats with i_start=0 accepted and discarded (not written); first beat with i_start=1 written -> WAIT_FRAME.
- WAIT_FRAME: beats written normally (stall on full). At raster (0,0): if FIFO non-empty, pop head -> LOCKED (head is start beat by construction); if empty, stay, retry next frame.
- LOCKED: o_locked=1; every active pixel pops one entry and displays it. Check per pop: start=1 iff (h,v)=(0,0); last=1 iff h_cnt=H_ACTIVE-1. Violation -> o_misalign pulse, pixel shown as 0, -> FLUSH. FIFO empty at active pixel -> o_underflow pulse, pixel 0, -> FLUSH.
- FLUSH: one cycle, FIFO emptied, o_ready=0 -> SEARCH.
- Blanking never pops. Underflow and misalign on same pixel: underflow only.

## Timing
- Reset: h_cnt=v_cnt=0, state SEARCH, FIFO empty; all outputs 0 (o_ready 0 during reset, 1 from first edge after release).
- Outputs registered, 1-cycle latency: vid_* at cycle n+1 reflect counter at cycle n. First cycle after reset release shows de=1 for pixel (0,0) with data 0.
- Beat accepted at cycle n is poppable at cycle n+1 earliest.
- o_locked rises on the cycle vid_de presents (0,0) of the first locked frame; falls the cycle after the faulting pixel appears.
- Reset mid-frame: immediate async clear of everything, raster restarts at (0,0).

## Test plan
- Small params (H 8/2/2/2, V 4/1/1/1, depth 8), no input -> de=1 for 8 of every 14 clocks on lines 0-3, hsync high h=10-11, vsync high on line 5, vid_data 0, o_locked 0.
- Feed 3 beats start=0 then aligned frame beginning start=1, pixels 0x000001.. -> first three dropped, lock at next (0,0), vid_data 0x000001 at first de, continuous thereafter.
- Locked, stall i_valid for 20 clocks mid-line -> o_underflow one pulse, pixel 0, o_locked falls, FIFO flushed, relock next frame.
- Locked, send line of 7 pixels (last on 7th) -> o_misalign pulse at h=6, pixel 0, SEARCH.
- Source always valid, FIFO full during blanking -> o_ready 0, no beat lost or duplicated; data 1..32 displayed in order.
- Assert reset mid-line while locked -> all outputs 0 asynchronously, o_locked 0; after release, raster at (0,0), relock on next start beat.
